// File: rtl/adder_pkg.sv
// Shared operation encoding and default geometry for the pipelined adder.
package adder_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    ACC = 2'd2,
    CLR = 2'd3
  } mode_e;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_STAGES = 2;

endpackage

// File: rtl/adder_pipe_stage.sv
// One valid/ready register slice carrying {cout, ovf, sum}; 1 cycle latency.
// Loads whenever empty or when its contents leave in the same cycle, so a full chain still streams.
module adder_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH+1:0] in_dat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] out_dat
);

  logic             r_vld;
  logic [WIDTH+1:0] r_dat;

  assign in_ready  = !r_vld || out_ready;
  assign out_valid = r_vld;
  assign out_dat   = r_dat;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (in_ready) begin
      r_vld <= in_valid;
      if (in_valid) begin
        r_dat <= in_dat;
      end
    end
  end

endmodule

// File: rtl/adder_pipe.sv
// ADD/SUB/ACC/CLR unit: arithmetic resolved at acceptance, result emerges STAGES cycles later.
// Output stall holds results in place and backs up to in_ready; pop and accept may coincide.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  mode_e            mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int PW = WIDTH + 2;

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_op1;
  logic [WIDTH-1:0] w_op2;
  logic             w_c;
  logic [WIDTH:0]   w_full;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic             w_accept;
  logic [PW-1:0]    w_pay;

  always_comb begin
    w_op1 = a;
    w_op2 = b;
    w_c   = cin;
    case (mode)
      SUB: begin
        w_op2 = ~b;
        w_c   = 1'b1;
      end
      ACC: begin
        w_op1 = r_acc;
        w_op2 = a;
      end
      default: ;
    endcase
  end

  assign w_full = {1'b0, w_op1} + {1'b0, w_op2} + {{WIDTH{1'b0}}, w_c};

  always_comb begin
    w_sum  = w_full[WIDTH-1:0];
    w_cout = w_full[WIDTH];
    w_ovf  = (w_op1[WIDTH-1] == w_op2[WIDTH-1]) && (w_full[WIDTH-1] != w_op1[WIDTH-1]);
    if (mode == CLR) begin
      w_sum  = '0;
      w_cout = 1'b0;
      w_ovf  = 1'b0;
    end
  end

  assign w_pay    = {w_cout, w_ovf, w_sum};
  assign w_accept = in_valid && in_ready;

  // Accumulator only moves on accepted ACC/CLR; CLR forces w_sum to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else if (w_accept && (mode == ACC || mode == CLR)) begin
      r_acc <= w_sum;
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stg
    logic          w_i_vld;
    logic          w_i_rdy;
    logic [PW-1:0] w_i_dat;
    logic          w_o_vld;
    logic          w_o_rdy;
    logic [PW-1:0] w_o_dat;

    adder_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .reset    (reset),
      .in_valid (w_i_vld),
      .in_ready (w_i_rdy),
      .in_dat   (w_i_dat),
      .out_valid(w_o_vld),
      .out_ready(w_o_rdy),
      .out_dat  (w_o_dat)
    );

    if (g == 0) begin : g_head
      assign w_i_vld = in_valid;
      assign w_i_dat = w_pay;
    end else begin : g_link
      assign w_i_vld = g_stg[g-1].w_o_vld;
      assign w_i_dat = g_stg[g-1].w_o_dat;
    end

    if (g == STAGES - 1) begin : g_tail
      assign w_o_rdy = out_ready;
    end else begin : g_back
      assign w_o_rdy = g_stg[g+1].w_i_rdy;
    end
  end

  assign in_ready          = g_stg[0].w_i_rdy && !reset;
  assign out_valid         = g_stg[STAGES-1].w_o_vld;
  assign {cout, ovf, sum}  = g_stg[STAGES-1].w_o_dat;

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: integer-arithmetic reference model with per-cycle compare, plus literal vectors.
module tb_adder_pipe;
  import adder_pkg::*;

  localparam int W  = 8;
  localparam int ST = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;
  mode_e        mode;

  logic         s1_in_valid, s1_in_ready, s1_cin, s1_out_valid, s1_out_ready, s1_cout, s1_ovf;
  logic [W-1:0] s1_a, s1_b, s1_sum;
  mode_e        s1_mode;

  adder_pipe #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  adder_pipe #(.WIDTH(W), .STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
    .a(s1_a), .b(s1_b), .cin(s1_cin), .mode(s1_mode),
    .out_valid(s1_out_valid), .out_ready(s1_out_ready), .sum(s1_sum), .cout(s1_cout), .ovf(s1_ovf)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       v;
    int         edge_n;
  } exp_t;

  function automatic exp_t model_op(input mode_e m, input logic [7:0] x, input logic [7:0] y,
                                    input logic ci, input logic [7:0] acc);
    exp_t r;
    int   t;
    int   st;
    r.s = '0; r.c = 1'b0; r.v = 1'b0; r.edge_n = 0;
    t = 0; st = 0;
    case (m)
      ADD: begin
        t   = int'(x) + int'(y) + int'(ci);
        st  = int'($signed(x)) + int'($signed(y)) + int'(ci);
        r.c = (t > 255);
      end
      SUB: begin
        t   = int'(x) - int'(y);
        st  = int'($signed(x)) - int'($signed(y));
        r.c = (x >= y);
      end
      ACC: begin
        t   = int'(acc) + int'(x) + int'(ci);
        st  = int'($signed(acc)) + int'($signed(x)) + int'(ci);
        r.c = (t > 255);
      end
      default: ;
    endcase
    r.s = t[7:0];
    r.v = (st > 127) || (st < -128);
    return r;
  endfunction

  exp_t       mq[$];
  logic [7:0] m_acc = '0;
  int         cyc = 0;
  bit         started = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) started <= 1'b1;
  end

  // Reference: results queue in acceptance order; head is visible once STAGES cycles old.
  always @(negedge clk) begin
    exp_t e;
    bit   er;
    bit   ev;
    bit   acc_now;
    if (started) begin
      er = !reset && (mq.size() < ST || out_ready);
      ev = (mq.size() > 0) && (cyc >= mq[0].edge_n + ST - 1);
      chk("model in_ready", in_ready, er);
      chk("model out_valid", out_valid, ev);
      if (ev) begin
        chk("model sum", sum, mq[0].s);
        chk("model cout", cout, mq[0].c);
        chk("model ovf", ovf, mq[0].v);
      end
      if (reset) begin
        mq.delete();
        m_acc = '0;
      end else begin
        acc_now = in_valid && er;
        if (acc_now) begin
          e = model_op(mode, a, b, cin, m_acc);
          e.edge_n = cyc + 1;
          if (mode == ACC) m_acc = e.s;
          else if (mode == CLR) m_acc = '0;
        end
        if (ev && out_ready) void'(mq.pop_front());
        if (acc_now) mq.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op_chk(input string name, input mode_e m, input logic [7:0] x, input logic [7:0] y,
                        input logic ci, input logic [7:0] es, input logic ec, input logic evf);
    int n;
    bit got;
    mode = m; a = x; b = y; cin = ci; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n = 1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
      else begin
        step();
        n++;
      end
    end
    chk({name, " latency"}, got ? n : -1, ST);
    if (got) begin
      chk({name, " sum"}, sum, es);
      chk({name, " cout"}, cout, ec);
      chk({name, " ovf"}, ovf, evf);
    end
    step();
  endtask

  logic [7:0] s_a [6];
  logic [7:0] s_b [6];
  logic       s_c [6];
  logic [7:0] x_s [6];
  logic       x_c [6];
  logic       x_v [6];
  logic [7:0] r_s [6];
  logic       r_c [6];
  logic       r_v [6];

  initial begin
    int         sent;
    int         popped;
    logic [7:0] hold_s;
    logic       hold_c;
    logic       hold_v;

    s_a = '{8'h01, 8'h7F, 8'hFF, 8'h80, 8'h10, 8'hAA};
    s_b = '{8'h02, 8'h01, 8'hFF, 8'h80, 8'h20, 8'h55};
    s_c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    x_s = '{8'h03, 8'h80, 8'hFE, 8'h00, 8'h31, 8'hFF};
    x_c = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    x_v = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    hold_s = '0; hold_c = 1'b0; hold_v = 1'b0;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; mode = ADD;
    s1_in_valid = 1'b0; s1_out_ready = 1'b1; s1_a = '0; s1_b = '0; s1_cin = 1'b0; s1_mode = ADD;
    repeat (3) step();
    @(negedge clk);
    chk("reset in_ready", in_ready, 1'b0);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset sum", sum, 8'h00);
    chk("reset cout", cout, 1'b0);
    chk("reset ovf", ovf, 1'b0);
    chk("reset s1 out_valid", s1_out_valid, 1'b0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset in_ready", in_ready, 1'b1);
    step();

    op_chk("add FF+01", ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op_chk("sub 80-01", SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
    op_chk("sub 05-05", SUB, 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0);
    op_chk("clr", CLR, 8'h12, 8'h34, 1'b1, 8'h00, 1'b0, 1'b0);
    op_chk("acc1", ACC, 8'h60, 8'hFF, 1'b0, 8'h60, 1'b0, 1'b0);
    op_chk("acc2", ACC, 8'h60, 8'h00, 1'b0, 8'hC0, 1'b0, 1'b1);
    op_chk("acc3", ACC, 8'h60, 8'h11, 1'b0, 8'h20, 1'b1, 1'b0);

    // Garbage on the operand bus while idle must not touch the accumulator.
    in_valid = 1'b0; mode = ACC; a = 8'h7F; cin = 1'b1;
    repeat (3) step();
    op_chk("acc idle-hold", ACC, 8'h00, 8'h00, 1'b0, 8'h20, 1'b0, 1'b0);

    sent = 0;
    popped = 0;
    for (int t = 0; t < 30 && popped < 6; t++) begin
      out_ready = !(t >= 2 && t <= 5);
      in_valid  = (sent < 6);
      if (sent < 6) begin
        mode = ADD; a = s_a[sent]; b = s_b[sent]; cin = s_c[sent];
      end
      @(negedge clk);
      if (t == 2) begin
        hold_s = sum; hold_c = cout; hold_v = ovf;
      end
      if (t == 3) chk("stall in_ready low", in_ready, 1'b0);
      if (t >= 3 && t <= 5) begin
        chk("stall sum stable", sum, hold_s);
        chk("stall cout stable", cout, hold_c);
        chk("stall ovf stable", ovf, hold_v);
      end
      if (t == 6) begin
        chk("full pop+push in_ready", in_ready, 1'b1);
        chk("full pop+push out_valid", out_valid, 1'b1);
      end
      if (out_valid && out_ready) begin
        r_s[popped] = sum; r_c[popped] = cout; r_v[popped] = ovf;
        popped++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream result count", popped, 6);
    for (int i = 0; i < 6 && i < popped; i++) begin
      chk($sformatf("stream[%0d] sum", i), r_s[i], x_s[i]);
      chk($sformatf("stream[%0d] cout", i), r_c[i], x_c[i]);
      chk($sformatf("stream[%0d] ovf", i), r_v[i], x_v[i]);
    end

    op_chk("pre-reset clr", CLR, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    op_chk("pre-reset acc 40", ACC, 8'h40, 8'h00, 1'b0, 8'h40, 1'b0, 1'b0);
    out_ready = 1'b0; in_valid = 1'b1; mode = ADD; a = 8'h01; b = 8'h01; cin = 1'b0;
    step();
    a = 8'h02; b = 8'h02;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("in-flight out_valid", out_valid, 1'b1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("flushed out_valid c%0d", i), out_valid, 1'b0);
      if (i == 0) chk("flushed in_ready", in_ready, 1'b1);
      step();
    end
    op_chk("acc after reset", ACC, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0);

    s1_mode = ADD; s1_a = 8'h01; s1_b = 8'h01; s1_in_valid = 1'b1;
    @(negedge clk);
    chk("s1 in_ready", s1_in_ready, 1'b1);
    step();
    s1_a = 8'h02; s1_b = 8'h02;
    @(negedge clk);
    chk("s1 first out_valid", s1_out_valid, 1'b1);
    chk("s1 first sum", s1_sum, 8'h02);
    chk("s1 second accept", s1_in_ready, 1'b1);
    step();
    s1_in_valid = 1'b0;
    @(negedge clk);
    chk("s1 second out_valid", s1_out_valid, 1'b1);
    chk("s1 second sum", s1_sum, 8'h04);
    step();
    @(negedge clk);
    chk("s1 drained out_valid", s1_out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule
